// File: rtl/alu_load_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_load_sequencer_if
// Purpose  : Board-side and ALU-side signal bundle for alu_load_sequencer.
//            slave  = sequencer view, master = board / ALU / testbench view.
// Revision : 1.0  initial release
// ============================================================================
interface alu_load_sequencer_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic               i_button;
  logic [NB_DATA-1:0] i_switches;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OP-1:0]   o_operation;
  logic [NB_DATA-1:0] o_result;
  logic               o_valid;
  logic [2:0]         o_state;
  logic               o_op_err;

  modport slave (
    input  i_button, i_switches, i_alu_result,
    output o_data_a, o_data_b, o_operation, o_result, o_valid, o_state, o_op_err
  );

  modport master (
    output i_button, i_switches, i_alu_result,
    input  o_data_a, o_data_b, o_operation, o_result, o_valid, o_state, o_op_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_load_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_load_sequencer
// Purpose  : Single-button sequencer for the ALU operand/opcode path.
//            A debounced "enter" button steps LOAD_A -> LOAD_B -> LOAD_OP ->
//            EXEC -> SHOW, latching the switches into A, B and the opcode,
//            then capturing and holding the ALU result for display.
// Options  : ALU_SEQ_OPCODE_CHECK_EN - reject unsupported opcodes in LOAD_OP
//            and pulse o_op_err; when undefined every opcode is accepted.
// Revision : 1.0  initial release
// ============================================================================
module alu_load_sequencer #(
  parameter int NB_DATA         = 8,
  parameter int NB_OP           = 6,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  wire logic           i_clock,
  input  wire logic           i_reset,
  alu_load_sequencer_if.slave bus
);

  // A counter of at least one bit keeps DEBOUNCE_CYCLES == 1 legal.
  localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_LOAD_A  = 3'd0,
    ST_LOAD_B  = 3'd1,
    ST_LOAD_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SHOW    = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic               r_btn_meta;
  logic               r_btn_sync;
  logic               r_btn_db;
  logic               r_btn_db_q;
  logic [c_CNT_W-1:0] r_db_cnt;
  logic               w_press;

  logic [NB_DATA-1:0] r_data_a;
  logic [NB_DATA-1:0] r_data_b;
  logic [NB_OP-1:0]   r_operation;
  logic [NB_DATA-1:0] r_result;
  logic               r_valid;
  logic               r_op_err;

  logic               w_op_ok;
  logic               w_load_a;
  logic               w_load_b;
  logic               w_load_op;
  logic               w_capture;
  logic               w_clear_valid;
  logic               w_op_reject;

  // Two-flop synchronizer for the raw, asynchronous button level.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
    end else begin
      r_btn_meta <= bus.i_button;
      r_btn_sync <= r_btn_meta;
    end
  end

  // Accept a level change only after it has been stable long enough; any
  // return to the accepted level restarts the count.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_btn_db   <= 1'b0;
      r_btn_db_q <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_btn_db_q <= r_btn_db;
      if (r_btn_sync != r_btn_db) begin
        if (r_db_cnt == c_CNT_LAST) begin
          r_btn_db <= ~r_btn_db;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + c_CNT_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  // One-cycle pulse per accepted rising edge of the debounced level.
  assign w_press = r_btn_db & ~r_btn_db_q;

`ifdef ALU_SEQ_OPCODE_CHECK_EN
  // Only the opcodes the ALU implements may be loaded.
  always_comb begin
    w_op_ok = 1'b0;
    case (bus.i_switches[NB_OP-1:0])
      NB_OP'(6'b100000),
      NB_OP'(6'b100010),
      NB_OP'(6'b100100),
      NB_OP'(6'b100101),
      NB_OP'(6'b100110),
      NB_OP'(6'b100111),
      NB_OP'(6'b000011),
      NB_OP'(6'b000010): w_op_ok = 1'b1;
      default:           w_op_ok = 1'b0;
    endcase
  end
`else
  // Without the check every opcode is accepted, so o_op_err never fires.
  assign w_op_ok = 1'b1;
`endif

  // Next-state and load-enable decode; EXEC lasts exactly one cycle and
  // ignores the button, unknown codes fall back to LOAD_A untouched.
  always_comb begin
    w_next_state  = r_state;
    w_load_a      = 1'b0;
    w_load_b      = 1'b0;
    w_load_op     = 1'b0;
    w_capture     = 1'b0;
    w_clear_valid = 1'b0;
    w_op_reject   = 1'b0;
    case (r_state)
      ST_LOAD_A: begin
        if (w_press) begin
          w_load_a     = 1'b1;
          w_next_state = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        if (w_press) begin
          w_load_b     = 1'b1;
          w_next_state = ST_LOAD_OP;
        end
      end
      ST_LOAD_OP: begin
        if (w_press) begin
          if (w_op_ok) begin
            w_load_op    = 1'b1;
            w_next_state = ST_EXEC;
          end else begin
            w_op_reject  = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        w_capture    = 1'b1;
        w_next_state = ST_SHOW;
      end
      ST_SHOW: begin
        if (w_press) begin
          w_clear_valid = 1'b1;
          w_next_state  = ST_LOAD_A;
        end
      end
      default: begin
        w_next_state = ST_LOAD_A;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_LOAD_A;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand, opcode and result registers; each only changes in its own step.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_data_a    <= '0;
      r_data_b    <= '0;
      r_operation <= '0;
      r_result    <= '0;
      r_valid     <= 1'b0;
      r_op_err    <= 1'b0;
    end else begin
      if (w_load_a) begin
        r_data_a <= bus.i_switches;
      end
      if (w_load_b) begin
        r_data_b <= bus.i_switches;
      end
      if (w_load_op) begin
        r_operation <= bus.i_switches[NB_OP-1:0];
      end
      if (w_capture) begin
        r_result <= bus.i_alu_result;
        r_valid  <= 1'b1;
      end else if (w_clear_valid) begin
        r_valid  <= 1'b0;
      end
      r_op_err <= w_op_reject;
    end
  end

  assign bus.o_data_a    = r_data_a;
  assign bus.o_data_b    = r_data_b;
  assign bus.o_operation = r_operation;
  assign bus.o_result    = r_result;
  assign bus.o_valid     = r_valid;
  assign bus.o_state     = r_state;
  assign bus.o_op_err    = r_op_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_load_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_load_sequencer
// Purpose  : Self-checking bench for alu_load_sequencer with an A+B stub ALU.
//            Honours ALU_SEQ_OPCODE_CHECK_EN when it is defined for the build.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_load_sequencer;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int DEB     = 4;
`ifdef ALU_SEQ_OPCODE_CHECK_EN
  localparam bit c_CHECK = 1'b1;
`else
  localparam bit c_CHECK = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_load_sequencer_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

  // Stub ALU: plain 8-bit addition of the two operand registers.
  assign bus.i_alu_result = bus.o_data_a + bus.o_data_b;

  alu_load_sequencer #(
    .NB_DATA         (NB_DATA),
    .NB_OP           (NB_OP),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: which value the next accepted press loads, plus the
  // values every output should hold once the press has settled.
  int         m_phase;
  logic [7:0] m_a, m_b, m_res;
  logic [5:0] m_op;
  logic       m_valid;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sw_op;
    logic [7:0] exp_op;
    logic [7:0] exp_res;
  } vec_t;
  vec_t tbl [5];

  function automatic bit op_legal(input logic [5:0] op);
    logic [5:0] legal [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
    bit hit = 1'b0;
    for (int i = 0; i < 8; i++) if (legal[i] == op) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [5:0] pick_legal(input int idx);
    logic [5:0] legal [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
    return legal[idx];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_valid = 1'b0;
  endtask

  task automatic check_outputs(input string nm);
    check({nm, " state"},  bus.o_state,     m_phase);
    check({nm, " a"},      bus.o_data_a,    m_a);
    check({nm, " b"},      bus.o_data_b,    m_b);
    check({nm, " op"},     bus.o_operation, m_op);
    check({nm, " result"}, bus.o_result,    m_res);
    check({nm, " valid"},  bus.o_valid,     m_valid);
    check({nm, " op_err"}, bus.o_op_err,    1'b0);
  endtask

  // Clean press: raw rise just after edge 0, release after edge 9, observe
  // through edge 20 so the release is fully accepted.
  task automatic press(input logic [7:0] sw, output int st6, output int st7,
                       output int st8, output int v7, output int v8, output int errc);
    errc = 0; st6 = 0; st7 = 0; st8 = 0; v7 = 0; v8 = 0;
    @(posedge clk); #1;
    bus.i_switches = sw;
    bus.i_button   = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (e == 6) st6 = int'(bus.o_state);
      if (e == 7) begin st7 = int'(bus.o_state); v7 = int'(bus.o_valid); end
      if (e == 8) begin st8 = int'(bus.o_state); v8 = int'(bus.o_valid); end
      if (bus.o_op_err) errc++;
      if (e == 9) bus.i_button = 1'b0;
    end
  endtask

  // Button high for k clock samples, then low long enough to settle.
  task automatic glitch(input int k);
    @(posedge clk); #1;
    bus.i_button = 1'b1;
    repeat (k) @(posedge clk);
    #1 bus.i_button = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  // One press applied to DUT and model, with timing and settled-value checks.
  task automatic do_step(input logic [7:0] sw, input string nm);
    int prev, exp7, exp8, exp_err;
    int st6, st7, st8, v7, v8, errc;
    prev = m_phase; exp_err = 0; exp7 = 0; exp8 = 0;
    case (m_phase)
      0: begin m_a = sw; m_phase = 1; end
      1: begin m_b = sw; m_phase = 2; end
      2: begin
        if (!c_CHECK || op_legal(sw[5:0])) begin
          m_op = sw[5:0]; m_res = m_a + m_b; m_valid = 1'b1; m_phase = 4;
        end else begin
          exp_err = 1;
        end
      end
      default: begin m_valid = 1'b0; m_phase = 0; end
    endcase
    if (prev == 2 && m_phase == 4) begin exp7 = 3; exp8 = 4; end
    else begin exp7 = m_phase; exp8 = m_phase; end
    press(sw, st6, st7, st8, v7, v8, errc);
    check({nm, " edge6 state"}, st6, prev);
    check({nm, " edge7 state"}, st7, exp7);
    check({nm, " edge8 state"}, st8, exp8);
    if (exp7 == 3) check({nm, " edge7 valid"}, v7, 0);
    check({nm, " edge8 valid"}, v8, int'(m_valid));
    check({nm, " op_err cycles"}, errc, exp_err);
    check_outputs(nm);
  endtask

  initial begin
    int trans, prev_st;
    logic [7:0] sw;

    tbl[0] = '{a: 8'h12, b: 8'h34, sw_op: 8'h20, exp_op: 8'h20, exp_res: 8'h46};
    tbl[1] = '{a: 8'hFF, b: 8'h01, sw_op: 8'hE2, exp_op: 8'h22, exp_res: 8'h00};
    tbl[2] = '{a: 8'h80, b: 8'h80, sw_op: 8'h43, exp_op: 8'h03, exp_res: 8'h00};
    tbl[3] = '{a: 8'h7F, b: 8'h01, sw_op: 8'hA4, exp_op: 8'h24, exp_res: 8'h80};
    tbl[4] = '{a: 8'h00, b: 8'h00, sw_op: 8'hC2, exp_op: 8'h02, exp_res: 8'h00};

    bus.i_button   = 1'b0;
    bus.i_switches = '0;
    model_reset();

    // Reset state while reset is held.
    repeat (3) @(posedge clk);
    #1 check_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Table: full sequences, including the 0x12+0x34 example and the
    // upper-switch-bit masking of the opcode.
    for (int i = 0; i < 5; i++) begin
      do_step(tbl[i].a, "tbl load a");
      do_step(tbl[i].b, "tbl load b");
      do_step(tbl[i].sw_op, "tbl load op");
      check("tbl op value", bus.o_operation, tbl[i].exp_op);
      check("tbl result value", bus.o_result, tbl[i].exp_res);
      check("tbl valid in show", bus.o_valid, 1'b1);
      do_step(8'h5A, "tbl back to a");
      check("tbl result held", bus.o_result, tbl[i].exp_res);
    end

    // Reset mid-LOAD_B with a press partly debounced.
    do_step(8'hAA, "rst pre a");
    @(posedge clk); #1;
    bus.i_switches = 8'hBB;
    bus.i_button   = 1'b1;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_outputs("mid-b reset async");
    bus.i_button = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 check_outputs("mid-b reset released");

    // Bounce: 3-cycle pulses with 2-cycle gaps must never be accepted.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 bus.i_button = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.i_button = 1'b0;
      repeat (1) @(posedge clk);
    end
    repeat (15) @(posedge clk);
    #1 check_outputs("bounce ignored");

    // Held button: exactly one transition over 100 cycles plus release.
    trans = 0;
    prev_st = int'(bus.o_state);
    bus.i_switches = 8'h55;
    bus.i_button   = 1'b1;
    for (int c = 0; c < 125; c++) begin
      @(posedge clk); #1;
      if (c == 100) bus.i_button = 1'b0;
      if (int'(bus.o_state) != prev_st) trans++;
      prev_st = int'(bus.o_state);
    end
    check("held button transitions", trans, 1);
    m_a = 8'h55; m_phase = 1;
    check_outputs("held button");

    // Async reset between edges while in EXEC.
    do_step(8'h66, "exec pre b");
    @(posedge clk); #1;
    bus.i_switches = 8'h24;
    bus.i_button   = 1'b1;
    repeat (7) @(posedge clk);
    #1 check("exec reached", bus.o_state, 3'd3);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs("exec async reset");
    bus.i_button = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 check_outputs("exec reset released");

    // Unsupported opcode then a supported one.
    do_step(8'h0F, "opchk a");
    do_step(8'h21, "opchk b");
    do_step(8'h3F, "opchk 3f");
    do_step(8'h22, "opchk 22");

    // Randomised presses with short ignored glitches in between.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) glitch(int'($urandom_range(1, DEB - 1)));
      sw = 8'($urandom);
      if (m_phase == 2 && $urandom_range(0, 1) == 1)
        sw = {sw[7:6], pick_legal(int'($urandom_range(0, 7)))};
      do_step(sw, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
